// File: rtl/param_ram_arbiter.sv
// Arbiter sharing one single-port synchronous-read parameter RAM between DSP reads (strict priority),
// posted host writes (8-deep FIFO) and request/valid host reads. Optional macro: PARAM_COMMIT_ON_FRAME_EN.
module param_ram_arbiter #(
  parameter int WORD_WIDTH = 36,
  parameter int ADDR_WIDTH = 10,
  parameter int FIFO_AW    = 3
) (
  input  logic                  clk,
  input  logic                  reset,
`ifdef PARAM_COMMIT_ON_FRAME_EN
  input  logic                  frame_sync,
`endif
  input  logic                  dsp_rd_en,
  input  logic [ADDR_WIDTH-1:0] dsp_rd_addr,
  output logic [WORD_WIDTH-1:0] dsp_rd_data,
  input  logic                  host_wr_en,
  input  logic [ADDR_WIDTH-1:0] host_wr_addr,
  input  logic [WORD_WIDTH-1:0] host_wr_data,
  output logic                  host_wr_full,
  output logic                  host_wr_overflow,
  input  logic                  host_rd_req,
  input  logic [ADDR_WIDTH-1:0] host_rd_addr,
  output logic                  host_rd_busy,
  output logic                  host_rd_valid,
  output logic [WORD_WIDTH-1:0] host_rd_data,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [WORD_WIDTH-1:0] ram_wdata,
  output logic                  ram_we,
  input  logic [WORD_WIDTH-1:0] ram_rdata
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] DEPTH_CNT = (FIFO_AW + 1)'(DEPTH);

  // Handshake: host_wr_en is a one-cycle push, accepted only when !host_wr_full;
  // host_rd_req is a one-cycle request, accepted only when !host_rd_busy;
  // host_rd_valid pulses for exactly one cycle with host_rd_data carrying the result.

  typedef enum logic [1:0] {
    RD_IDLE    = 2'd0,
    RD_PENDING = 2'd1,
    RD_ISSUED  = 2'd2
  } rd_state_t;

  rd_state_t rd_state, rd_state_next;

  logic [ADDR_WIDTH-1:0] fifo_addr [DEPTH];
  logic [WORD_WIDTH-1:0] fifo_data [DEPTH];
  logic [FIFO_AW-1:0]    wr_ptr;
  logic [FIFO_AW-1:0]    rd_ptr;
  logic [FIFO_AW:0]      count;

  logic [ADDR_WIDTH-1:0] rd_addr_q;
  logic [WORD_WIDTH-1:0] rd_data_q;

  logic fifo_empty;
  logic push;
  logic pop;
  logic pop_allowed;
  logic rd_order_ok;
  logic grant_rd;
  logic grant_wr;
  logic rd_latch;
  logic rd_capture;

  assign fifo_empty   = (count == '0);
  assign host_wr_full = (count == DEPTH_CNT);
  assign push         = host_wr_en && !host_wr_full;
  assign pop          = grant_wr;

`ifdef PARAM_COMMIT_ON_FRAME_EN
  logic [FIFO_AW:0] commit_remaining;

  // Writes only drain inside a commit window; reads go straight to the RAM.
  assign pop_allowed = !fifo_empty && (commit_remaining != '0);
  assign rd_order_ok = 1'b1;

  // Setting the window to the whole FIFO count also folds in entries queued since the last sync.
  always_ff @(posedge clk) begin
    if (reset) begin
      commit_remaining <= '0;
    end else if (frame_sync) begin
      commit_remaining <= count - (FIFO_AW + 1)'(pop);
    end else if (pop) begin
      commit_remaining <= commit_remaining - 1'b1;
    end
  end
`else
  assign pop_allowed = !fifo_empty;
  assign rd_order_ok = fifo_empty;
`endif

  // Slot grant: DSP read, then host read, then FIFO drain.
  always_comb begin
    grant_rd  = 1'b0;
    grant_wr  = 1'b0;
    ram_addr  = dsp_rd_addr;
    ram_wdata = fifo_data[rd_ptr];
    ram_we    = 1'b0;
    if (dsp_rd_en) begin
      ram_addr = dsp_rd_addr;
    end else if ((rd_state == RD_PENDING) && rd_order_ok) begin
      grant_rd = 1'b1;
      ram_addr = rd_addr_q;
    end else if (pop_allowed) begin
      grant_wr = !reset;
      ram_addr = fifo_addr[rd_ptr];
      ram_we   = !reset;
    end
  end

  assign dsp_rd_data = ram_rdata;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr] <= host_wr_addr;
      fifo_data[wr_ptr] <= host_wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr           <= '0;
      rd_ptr           <= '0;
      count            <= '0;
      host_wr_overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
      if (host_wr_en && host_wr_full) host_wr_overflow <= 1'b1;
    end
  end

  // Host read FSM; ISSUED is the cycle the RAM returns the requested word.
  always_comb begin
    rd_state_next = rd_state;
    rd_latch      = 1'b0;
    rd_capture    = 1'b0;
    case (rd_state)
      RD_IDLE: begin
        if (host_rd_req) begin
          rd_latch      = 1'b1;
          rd_state_next = RD_PENDING;
        end
      end
      RD_PENDING: begin
        if (grant_rd) rd_state_next = RD_ISSUED;
      end
      RD_ISSUED: begin
        rd_capture = 1'b1;
        if (host_rd_req) begin
          rd_latch      = 1'b1;
          rd_state_next = RD_PENDING;
        end else begin
          rd_state_next = RD_IDLE;
        end
      end
      default: rd_state_next = RD_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_state  <= RD_IDLE;
      rd_addr_q <= '0;
      rd_data_q <= '0;
    end else begin
      rd_state <= rd_state_next;
      if (rd_latch)   rd_addr_q <= host_rd_addr;
      if (rd_capture) rd_data_q <= ram_rdata;
    end
  end

  assign host_rd_busy  = (rd_state == RD_PENDING);
  assign host_rd_valid = (rd_state == RD_ISSUED) && !reset;
  // The word is forwarded in its valid cycle and held in rd_data_q afterwards.
  assign host_rd_data  = host_rd_valid ? ram_rdata : rd_data_q;

endmodule

// File: tb/tb_param_ram_arbiter.sv
// Directed bench for param_ram_arbiter with a behavioural synchronous-read RAM attached.
module tb_param_ram_arbiter;

  localparam int WW = 36;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          reset;
  logic          dsp_rd_en;
  logic [AW-1:0] dsp_rd_addr;
  logic [WW-1:0] dsp_rd_data;
  logic          host_wr_en;
  logic [AW-1:0] host_wr_addr;
  logic [WW-1:0] host_wr_data;
  logic          host_wr_full;
  logic          host_wr_overflow;
  logic          host_rd_req;
  logic [AW-1:0] host_rd_addr;
  logic          host_rd_busy;
  logic          host_rd_valid;
  logic [WW-1:0] host_rd_data;
  logic [AW-1:0] ram_addr;
  logic [WW-1:0] ram_wdata;
  logic          ram_we;
  logic [WW-1:0] ram_rdata = '0;
`ifdef PARAM_COMMIT_ON_FRAME_EN
  logic          frame_sync;
`endif

  int tests_run    = 0;
  int tests_failed = 0;
  int nvalid;

  logic [WW-1:0] mem [1<<AW];

  param_ram_arbiter #(.WORD_WIDTH(WW), .ADDR_WIDTH(AW), .FIFO_AW(3)) dut (
    .clk              (clk),
    .reset            (reset),
`ifdef PARAM_COMMIT_ON_FRAME_EN
    .frame_sync       (frame_sync),
`endif
    .dsp_rd_en        (dsp_rd_en),
    .dsp_rd_addr      (dsp_rd_addr),
    .dsp_rd_data      (dsp_rd_data),
    .host_wr_en       (host_wr_en),
    .host_wr_addr     (host_wr_addr),
    .host_wr_data     (host_wr_data),
    .host_wr_full     (host_wr_full),
    .host_wr_overflow (host_wr_overflow),
    .host_rd_req      (host_rd_req),
    .host_rd_addr     (host_rd_addr),
    .host_rd_busy     (host_rd_busy),
    .host_rd_valid    (host_rd_valid),
    .host_rd_data     (host_rd_data),
    .ram_addr         (ram_addr),
    .ram_wdata        (ram_wdata),
    .ram_we           (ram_we),
    .ram_rdata        (ram_rdata)
  );

  // clock / reset block
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #2;
  endtask

  task automatic push(input logic [AW-1:0] a, input logic [WW-1:0] d);
    host_wr_en   = 1'b1;
    host_wr_addr = a;
    host_wr_data = d;
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
    reset        = 1'b1;
    dsp_rd_en    = 1'b0;
    dsp_rd_addr  = '0;
    host_wr_en   = 1'b0;
    host_wr_addr = '0;
    host_wr_data = '0;
    host_rd_req  = 1'b0;
    host_rd_addr = '0;
`ifdef PARAM_COMMIT_ON_FRAME_EN
    frame_sync   = 1'b0;
`endif
    step;
    step;
    settle;
    check_eq("rst_full", host_wr_full, 0);
    check_eq("rst_ovf", host_wr_overflow, 0);
    check_eq("rst_busy", host_rd_busy, 0);
    check_eq("rst_valid", host_rd_valid, 0);
    check_eq("rst_rd_data", host_rd_data, 0);
    check_eq("rst_we", ram_we, 0);
    step;
    reset = 1'b0;

`ifndef PARAM_COMMIT_ON_FRAME_EN
    // single posted write
    push(5, 36'h123456789);
    settle;
    check_eq("t1_we_push_cycle", ram_we, 0);
    step;
    host_wr_en = 1'b0;
    settle;
    check_eq("t1_we", ram_we, 1);
    check_eq("t1_addr", ram_addr, 5);
    check_eq("t1_wdata", ram_wdata, 36'h123456789);
    step;
    settle;
    check_eq("t1_we_after", ram_we, 0);
    check_eq("t1_full", host_wr_full, 0);

    // write then read of the same address in one cycle
    push(5, 36'hABC);
    host_rd_req  = 1'b1;
    host_rd_addr = 5;
    settle;
    check_eq("t2_busy_req_cycle", host_rd_busy, 0);
    step;
    host_wr_en  = 1'b0;
    host_rd_req = 1'b0;
    settle;
    check_eq("t2_write_first", ram_we, 1);
    check_eq("t2_wdata", ram_wdata, 36'hABC);
    check_eq("t2_busy", host_rd_busy, 1);
    check_eq("t2_no_valid_early", host_rd_valid, 0);
    step;
    settle;
    check_eq("t2_read_slot_we", ram_we, 0);
    check_eq("t2_read_slot_addr", ram_addr, 5);
    check_eq("t2_no_valid_grant", host_rd_valid, 0);
    step;
    settle;
    check_eq("t2_valid", host_rd_valid, 1);
    check_eq("t2_rd_data", host_rd_data, 36'hABC);
    check_eq("t2_busy_drop", host_rd_busy, 0);
    step;
    settle;
    check_eq("t2_valid_pulse", host_rd_valid, 0);
    check_eq("t2_rd_data_held", host_rd_data, 36'hABC);

    // DSP holds the RAM for 20 cycles while 3 writes queue up
    for (int i = 0; i < 20; i++) begin
      dsp_rd_en   = 1'b1;
      dsp_rd_addr = 5;
      if (i < 3) push(AW'(10 + i), WW'(36'h111 * (i + 1)));
      else host_wr_en = 1'b0;
      settle;
      check_eq("t3_dsp_no_we", ram_we, 0);
      check_eq("t3_dsp_addr", ram_addr, 5);
      if (i == 1) check_eq("t3_dsp_rd_data", dsp_rd_data, 36'hABC);
      step;
    end
    dsp_rd_en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      settle;
      check_eq("t3_drain_we", ram_we, 1);
      check_eq("t3_drain_addr", ram_addr, 64'(10 + k));
      check_eq("t3_drain_wdata", ram_wdata, 64'(36'h111 * (k + 1)));
      step;
    end
    settle;
    check_eq("t3_drain_done", ram_we, 0);

    // fill the FIFO behind the DSP and overflow it
    for (int i = 0; i < 9; i++) begin
      dsp_rd_en = 1'b1;
      push(AW'(20 + i), WW'(36'h500 + i));
      settle;
      check_eq("t4_full", host_wr_full, 64'(i >= 8));
      if (i == 8) check_eq("t4_ovf_before", host_wr_overflow, 0);
      step;
    end
    host_wr_en = 1'b0;
    settle;
    check_eq("t4_full_after", host_wr_full, 1);
    check_eq("t4_ovf", host_wr_overflow, 1);
    step;
    dsp_rd_en = 1'b0;
    for (int k = 0; k < 8; k++) begin
      settle;
      check_eq("t4_drain_we", ram_we, 1);
      check_eq("t4_drain_addr", ram_addr, 64'(20 + k));
      check_eq("t4_drain_wdata", ram_wdata, 64'(36'h500 + k));
      step;
    end
    settle;
    check_eq("t4_ninth_dropped", ram_we, 0);
    check_eq("t4_ovf_sticky", host_wr_overflow, 1);
    check_eq("t4_not_full", host_wr_full, 0);

    // second request while busy is ignored
    push(7, 36'h777);
    step;
    push(9, 36'h999);
    step;
    host_wr_en = 1'b0;
    step;
    step;
    step;
    host_rd_req  = 1'b1;
    host_rd_addr = 7;
    step;
    host_rd_addr = 9;
    settle;
    check_eq("t5_busy", host_rd_busy, 1);
    check_eq("t5_read_addr", ram_addr, 7);
    step;
    host_rd_req = 1'b0;
    settle;
    check_eq("t5_valid", host_rd_valid, 1);
    check_eq("t5_rd_data", host_rd_data, 36'h777);
    nvalid = 0;
    step;
    for (int k = 0; k < 6; k++) begin
      settle;
      if (host_rd_valid) nvalid++;
      step;
    end
    check_eq("t5_extra_valid", nvalid, 0);
    check_eq("t5_rd_data_held", host_rd_data, 36'h777);

    // reset with queued writes and a pending read
    dsp_rd_en = 1'b1;
    push(40, 36'hAAA);
    step;
    push(41, 36'hBBB);
    host_rd_req  = 1'b1;
    host_rd_addr = 40;
    step;
    host_wr_en  = 1'b0;
    host_rd_req = 1'b0;
    dsp_rd_en   = 1'b0;
    settle;
    check_eq("t6_ovf_before_reset", host_wr_overflow, 1);
    check_eq("t6_we_before", ram_we, 1);
    check_eq("t6_addr_before", ram_addr, 40);
    step;
    reset = 1'b1;
    settle;
    check_eq("t6_we_in_reset", ram_we, 0);
    step;
    reset = 1'b0;
    settle;
    check_eq("t6_we_after", ram_we, 0);
    check_eq("t6_busy_after", host_rd_busy, 0);
    check_eq("t6_ovf_after", host_wr_overflow, 0);
    check_eq("t6_rd_data_after", host_rd_data, 0);
    nvalid = 0;
    for (int k = 0; k < 4; k++) begin
      settle;
      if (host_rd_valid || ram_we) nvalid++;
      step;
    end
    check_eq("t6_quiet_after_reset", nvalid, 0);
`else
    // writes wait for a commit window
    push(30, 36'hA30);
    step;
    push(31, 36'hA31);
    step;
    host_wr_en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      settle;
      check_eq("f_no_commit_we", ram_we, 0);
      step;
    end
    frame_sync = 1'b1;
    settle;
    check_eq("f_sync_cycle_we", ram_we, 0);
    step;
    frame_sync = 1'b0;
    push(32, 36'hA32);
    settle;
    check_eq("f_we0", ram_we, 1);
    check_eq("f_addr0", ram_addr, 30);
    step;
    host_wr_en = 1'b0;
    settle;
    check_eq("f_we1", ram_we, 1);
    check_eq("f_addr1", ram_addr, 31);
    step;
    settle;
    check_eq("f_window_closed", ram_we, 0);
    step;
    settle;
    check_eq("f_third_waits", ram_we, 0);
    frame_sync = 1'b1;
    step;
    frame_sync = 1'b0;
    settle;
    check_eq("f_we2", ram_we, 1);
    check_eq("f_addr2", ram_addr, 32);
    check_eq("f_wdata2", ram_wdata, 36'hA32);
    step;
    settle;
    check_eq("f_done", ram_we, 0);

    // read bypasses the uncommitted write and sees the old contents
    push(50, 36'hBEEF);
    host_rd_req  = 1'b1;
    host_rd_addr = 50;
    step;
    host_wr_en  = 1'b0;
    host_rd_req = 1'b0;
    settle;
    check_eq("f_rd_grant_we", ram_we, 0);
    check_eq("f_rd_grant_addr", ram_addr, 50);
    step;
    settle;
    check_eq("f_rd_valid", host_rd_valid, 1);
    check_eq("f_rd_data_old", host_rd_data, 0);
    step;
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/param_ram_arbiter.md
Name: param_ram_arbiter

Overview:
Shares one single-port, synchronous-read parameter RAM between the DSP core and the host side. The host side is the SPI packet-to-memory adapter's read and write ports.
- DSP reads have strict priority.
- Host writes are posted into a small FIFO and drained into free slots.
- Host reads are request/valid transactions.
- Sits between the SPI memory adapter and the coefficient RAM.

Parameters:
WORD_WIDTH, 36, RAM data width
ADDR_WIDTH, 10, RAM address width
FIFO_AW, 3, log2 of host write FIFO depth (depth 8)

Ports:
clk  in  1  system clock; all logic on rising edge
reset  in  1  synchronous, active-high reset
dsp_rd_en  in  1  DSP read request this cycle
dsp_rd_addr  in  ADDR_WIDTH  DSP read address
dsp_rd_data  out  WORD_WIDTH  RAM read data; valid the cycle after dsp_rd_en
host_wr_en  in  1  single-cycle strobe: push {host_wr_addr, host_wr_data}
host_wr_addr  in  ADDR_WIDTH  host write address
host_wr_data  in  WORD_WIDTH  host write data
host_wr_full  out  1  FIFO full (registered count == depth)
host_wr_overflow  out  1  sticky: a push was dropped
host_rd_req  in  1  single-cycle strobe: start host read of host_rd_addr
host_rd_addr  in  ADDR_WIDTH  host read address, sampled on host_rd_req
host_rd_busy  out  1  host read outstanding
host_rd_valid  out  1  one-cycle pulse: host_rd_data updated
host_rd_data  out  WORD_WIDTH  last host read result, held
ram_addr  out  ADDR_WIDTH  RAM address
ram_wdata  out  WORD_WIDTH  RAM write data
ram_we  out  1  RAM write enable
ram_rdata  in  WORD_WIDTH  RAM read data, 1-cycle latency

Behaviour:
- Reset values: FIFO empty; host_wr_full=0; host_wr_overflow=0; host_rd_busy=0; host_rd_valid=0; host_rd_data=0; ram_we=0. ram_addr and ram_wdata are don't-care while ram_we=0.
- Slot grant is combinational each cycle, fixed priority:
  1. dsp_rd_en: ram_addr=dsp_rd_addr, ram_we=0.
  2. Else pending host read and FIFO empty: ram_addr=latched read address, ram_we=0.
  3. Else FIFO non-empty: pop the head; ram_addr/ram_wdata=head entry, ram_we=1.
  4. Else idle.
- dsp_rd_data = ram_rdata, passed straight through. The DSP always owns the cycle after its own request. No DSP stall exists.
- Ordering: host reads wait until the FIFO is empty, so a read always observes every earlier-accepted host write (read-after-write safe).
- Host read state machine, IDLE -> PENDING -> ISSUED -> IDLE:
  - IDLE: host_rd_req latches the address and goes to PENDING. busy=1 from the next cycle.
  - PENDING: when granted, go to ISSUED.
  - ISSUED: capture ram_rdata into host_rd_data, pulse host_rd_valid, go to IDLE. busy drops in the same cycle valid pulses.
  - host_rd_req while busy is ignored and has no side effects.
- Minimum read latency: req at cycle N -> grant N+1 -> valid at N+2.
- FIFO:
  - Push accepted when count < depth.
  - Push while full is dropped (even if a pop occurs that cycle) and sets host_wr_overflow.
  - Simultaneous push and pop when not full: count unchanged.
  - Pointers wrap modulo depth.
- Starvation: continuous dsp_rd_en stalls host traffic indefinitely. This is by design; the DSP schedule must leave gaps.
- Reset mid-operation clears the FIFO and any pending read, with no valid pulse. A RAM write in the reset cycle is suppressed (ram_we=0).

Optional Feature:
PARAM_COMMIT_ON_FRAME_EN.
- When defined:
  - Adds input frame_sync (1 bit, single-cycle pulse).
  - Writes drain only during commit windows. On frame_sync, the current FIFO count is latched into commit_remaining, and only that many entries are popped. Later pushes wait for the next frame_sync.
  - A frame_sync arriving while commit_remaining>0 adds the newly queued entries to it.
  - Host reads no longer wait for FIFO empty; they return the current RAM contents.
- When undefined: no frame_sync port; behaviour as above.

Test Plan:
- Reset, then push (addr 5, 0x123456789) with DSP idle -> ram_we=1, ram_addr=5 the next cycle; FIFO empty after.
- Push (addr 5, 0xABC), then host_rd_req addr 5 on the same cycle -> write precedes read; host_rd_data=0xABC, valid pulses 2 cycles after the write cycle.
- dsp_rd_en held high for 20 cycles with 3 queued writes -> ram_we=0 throughout; writes drain in the next 3 free cycles in FIFO order.
- 9 pushes back-to-back with dsp_rd_en high -> host_wr_full after 8; 9th dropped; host_wr_overflow=1 until reset.
- host_rd_req addr 7, second host_rd_req addr 9 while busy -> exactly one valid pulse, carrying mem[7].
- With PARAM_COMMIT_ON_FRAME_EN: queue 2 writes, no frame_sync -> ram_we stays 0. frame_sync -> exactly 2 writes. A 3rd push during the window waits for the next frame_sync.
